ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage LEGv8 pipeline.
- Consumes the ID/EX register contents and the forwarding unit's forwardA, forwardB and forwardFlag selects.
- Muxes the operands, runs the ALU, and holds the NZCV flag register.
- Registers the EX/MEM pipeline outputs. ExMem_RegWrite and ExMem_Rd feed straight back to the forwarding unit, and EXflag drives its flag-forward logic.

Parameters:
WIDTH, 64, datapath width in bits

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold EX/MEM register and flag register
flush  in  1  squash the instruction in EX; a bubble enters EX/MEM
IdEx_RegWrite  in  1  writes the register file
IdEx_MemWrite  in  1  store instruction
IdEx_MemToReg  in  1  load instruction
IdEx_SetFlags  in  1  instruction updates NZCV
IdEx_ALUOp  in  3  ALU operation select
IdEx_ALUSrc  in  1  1 = immediate used as ALU operand B
IdEx_Imm  in  WIDTH  sign/zero-extended immediate
IdEx_Rd  in  5  destination register
IdEx_ReadData1  in  WIDTH  register-file value for Rn
IdEx_ReadData2  in  WIDTH  register-file value for Rm
forwardA  in  2  operand A source select
forwardB  in  2  operand B source select
forwardFlag  in  1  1 = branch uses the stored flags
MemWr_WriteData  in  WIDTH  write-back result
EXflag  out  1  the instruction in EX sets flags (combinational)
branchFlags  out  4  NZCV presented to the branch logic (combinational)
flags  out  4  NZCV flag register {N,Z,C,V}
ExMem_RegWrite  out  1  registered control
ExMem_MemWrite  out  1  registered control
ExMem_MemToReg  out  1  registered control
ExMem_Rd  out  5  registered destination
ExMem_ALUResult  out  WIDTH  registered ALU result
ExMem_StoreData  out  WIDTH  registered forwarded Rm value, used as store data

Behaviour:
- Reset (asynchronous, reset_n=0, may assert mid-operation):
  - All ExMem_* controls go to 0.
  - ExMem_Rd goes to 31.
  - ExMem_ALUResult and ExMem_StoreData go to 0.
  - flags goes to 4'b0000.
  - Recovery is on the first rising edge after reset_n=1.
- Operand select:
  - forwardA: 00 selects IdEx_ReadData1; 10 selects ExMem_ALUResult; 01 selects MemWr_WriteData; 11 is treated as 00.
  - fwdB is selected from forwardB the same way, using IdEx_ReadData2.
  - ALU B = IdEx_ALUSrc ? IdEx_Imm : fwdB.
  - Store data is always fwdB.
- ALU ops:
  - 000 PASS_B.
  - 010 ADD.
  - 011 SUB, computed as A + ~B + 1.
  - 100 AND; 101 ORR; 110 EOR.
  - 001 and 111 produce result 0.
- ALU flags:
  - N = result[WIDTH-1]; Z = (result == 0).
  - ADD/SUB: C = carry-out of bit WIDTH-1 (SUB: C=1 means no borrow); V = signed overflow.
  - All other ops: C = 0, V = 0.
  - Arithmetic is modulo 2^WIDTH.
- Combinational outputs:
  - EXflag = IdEx_SetFlags.
  - branchFlags = forwardFlag ? flags : live ALU flags (bypass of the flag-setting instruction currently in EX).
- Pipeline register, 1-cycle latency, priority flush > stall > normal:
  - flush=1: load a bubble (all controls 0, Rd=31, data 0); flags unchanged.
  - stall=1, flush=0: all EX/MEM registers and flags hold.
  - Normal: capture controls, Rd, ALU result and store data; flags <= ALU flags only if IdEx_SetFlags=1.
- Forwarding from ExMem_ALUResult uses the current register value (the previous instruction), never the value being written this edge.
- Rd=31 (XZR) passes through unchanged; squashing writes to XZR is the forwarding unit's job, not this block's.

Test Plan:
- Reset mid-stream: assert reset_n=0 while ExMem_RegWrite=1 and flags=4'b0110 -> ExMem_RegWrite=0, ExMem_Rd=31, flags=0 immediately, without waiting for a clock edge.
- Back-to-back ADD, forwardA=10: ExMem_ALUResult=5, IdEx_ReadData1=99, Imm=3, ALUSrc=1, ALUOp=010 -> next ExMem_ALUResult=8.
- SUBS with forwardB=01: A=5, MemWr_WriteData=5 -> branchFlags=0110 in the same cycle (forwardFlag=0); flags=0110 after the edge.
- ADDS 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, flags=1001. Then AND with SetFlags=0 and forwardFlag=1 -> branchFlags=1001, flags unchanged.
- stall=1 for 2 cycles with new ID/EX inputs -> ExMem_* and flags hold. Then flush=1 and stall=1 together -> bubble loaded, Rd=31.
- forwardA=11, ReadData1=7, ExMem_ALUResult=1, PASS_B with B=7 / ADD 7+0 -> result 7, confirming 11 behaves as register-file select.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if
//   Bundles the signals between the ID/EX register, forwarding unit and
//   EX/MEM register and the execute stage.
//   slave  : the execute stage (consumes ID/EX + forwarding, drives EX/MEM)
//   master : the surrounding pipeline (drives ID/EX + forwarding, observes EX/MEM)
//   Signals:
//     stall, flush                   pipeline control
//     IdEx_*                         ID/EX register contents
//     forwardA/B, forwardFlag        forwarding-unit selects
//     MemWr_WriteData                write-back result for forwarding
//     EXflag, branchFlags            combinational outputs
//     flags, ExMem_*                 registered outputs
interface ex_stage_if #(
   parameter int WIDTH = 64
);
   logic             stall;
   logic             flush;
   logic             IdEx_RegWrite;
   logic             IdEx_MemWrite;
   logic             IdEx_MemToReg;
   logic             IdEx_SetFlags;
   logic [2:0]       IdEx_ALUOp;
   logic             IdEx_ALUSrc;
   logic [WIDTH-1:0] IdEx_Imm;
   logic [4:0]       IdEx_Rd;
   logic [WIDTH-1:0] IdEx_ReadData1;
   logic [WIDTH-1:0] IdEx_ReadData2;
   logic [1:0]       forwardA;
   logic [1:0]       forwardB;
   logic             forwardFlag;
   logic [WIDTH-1:0] MemWr_WriteData;
   logic             EXflag;
   logic [3:0]       branchFlags;
   logic [3:0]       flags;
   logic             ExMem_RegWrite;
   logic             ExMem_MemWrite;
   logic             ExMem_MemToReg;
   logic [4:0]       ExMem_Rd;
   logic [WIDTH-1:0] ExMem_ALUResult;
   logic [WIDTH-1:0] ExMem_StoreData;

   modport slave (
      input  stall, flush,
      input  IdEx_RegWrite, IdEx_MemWrite, IdEx_MemToReg, IdEx_SetFlags,
      input  IdEx_ALUOp, IdEx_ALUSrc, IdEx_Imm, IdEx_Rd,
      input  IdEx_ReadData1, IdEx_ReadData2,
      input  forwardA, forwardB, forwardFlag, MemWr_WriteData,
      output EXflag, branchFlags, flags,
      output ExMem_RegWrite, ExMem_MemWrite, ExMem_MemToReg, ExMem_Rd,
      output ExMem_ALUResult, ExMem_StoreData
   );

   modport master (
      output stall, flush,
      output IdEx_RegWrite, IdEx_MemWrite, IdEx_MemToReg, IdEx_SetFlags,
      output IdEx_ALUOp, IdEx_ALUSrc, IdEx_Imm, IdEx_Rd,
      output IdEx_ReadData1, IdEx_ReadData2,
      output forwardA, forwardB, forwardFlag, MemWr_WriteData,
      input  EXflag, branchFlags, flags,
      input  ExMem_RegWrite, ExMem_MemWrite, ExMem_MemToReg, ExMem_Rd,
      input  ExMem_ALUResult, ExMem_StoreData
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage of the 5-stage LEGv8 pipeline: forwarding muxes, ALU,
//   NZCV flag register and the EX/MEM pipeline register.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      ex_stage_if.slave (ID/EX inputs, forwarding selects,
//              EX/MEM outputs, flags, EXflag, branchFlags)
module ex_stage #(
   parameter int WIDTH = 64
) (
   input logic       clk,
   input logic       reset_n,
   ex_stage_if.slave bus
);
   localparam logic [2:0] OP_PASS_B = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_SUB    = 3'b011;
   localparam logic [2:0] OP_AND    = 3'b100;
   localparam logic [2:0] OP_ORR    = 3'b101;
   localparam logic [2:0] OP_EOR    = 3'b110;
   localparam logic [4:0] XZR       = 5'd31;

   // EX/MEM and flag state
   logic             reg_write_reg;
   logic             mem_write_reg;
   logic             mem_to_reg_reg;
   logic [4:0]       rd_reg;
   logic [WIDTH-1:0] alu_result_reg;
   logic [WIDTH-1:0] store_data_reg;
   logic [3:0]       flags_reg;

   // datapath
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] fwd_b;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] b_addend;
   logic [WIDTH:0]   sum;
   logic             is_sub;
   logic             is_arith;
   logic             overflow;
   logic [WIDTH-1:0] alu_result;
   logic [3:0]       alu_flags;

   // Operand forwarding. Forwarding from EX/MEM always uses the registered
   // value of the previous instruction; select 11 falls back to the register file.
   always_comb begin
      case (bus.forwardA)
         2'b10:   op_a = alu_result_reg;
         2'b01:   op_a = bus.MemWr_WriteData;
         default: op_a = bus.IdEx_ReadData1;
      endcase
      case (bus.forwardB)
         2'b10:   fwd_b = alu_result_reg;
         2'b01:   fwd_b = bus.MemWr_WriteData;
         default: fwd_b = bus.IdEx_ReadData2;
      endcase
      op_b = bus.IdEx_ALUSrc ? bus.IdEx_Imm : fwd_b;
   end

   // One shared adder serves ADD and SUB; SUB is A + ~B + 1 so the carry-out
   // directly gives the "no borrow" C flag.
   always_comb begin
      is_sub   = (bus.IdEx_ALUOp == OP_SUB);
      is_arith = (bus.IdEx_ALUOp == OP_ADD) || is_sub;
      b_addend = is_sub ? ~op_b : op_b;
      sum      = {1'b0, op_a} + {1'b0, b_addend} + {{WIDTH{1'b0}}, is_sub};
      // Overflow: both addends share a sign that the sum does not.
      overflow = (op_a[WIDTH-1] == b_addend[WIDTH-1]) &&
                 (sum[WIDTH-1] != op_a[WIDTH-1]);

      case (bus.IdEx_ALUOp)
         OP_PASS_B:      alu_result = op_b;
         OP_ADD, OP_SUB: alu_result = sum[WIDTH-1:0];
         OP_AND:         alu_result = op_a & op_b;
         OP_ORR:         alu_result = op_a | op_b;
         OP_EOR:         alu_result = op_a ^ op_b;
         default:        alu_result = '0;
      endcase

      alu_flags = {alu_result[WIDTH-1],
                   (alu_result == '0),
                   is_arith & sum[WIDTH],
                   is_arith & overflow};
   end

   // Flush beats stall; a stall freezes both the EX/MEM register and NZCV.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_write_reg  <= 1'b0;
         mem_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         rd_reg         <= XZR;
         alu_result_reg <= '0;
         store_data_reg <= '0;
         flags_reg      <= 4'b0000;
      end else if (bus.flush) begin
         reg_write_reg  <= 1'b0;
         mem_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         rd_reg         <= XZR;
         alu_result_reg <= '0;
         store_data_reg <= '0;
      end else if (!bus.stall) begin
         reg_write_reg  <= bus.IdEx_RegWrite;
         mem_write_reg  <= bus.IdEx_MemWrite;
         mem_to_reg_reg <= bus.IdEx_MemToReg;
         rd_reg         <= bus.IdEx_Rd;
         alu_result_reg <= alu_result;
         store_data_reg <= fwd_b;
         if (bus.IdEx_SetFlags) begin
            flags_reg <= alu_flags;
         end
      end
   end

   // branchFlags bypasses the live ALU flags so a branch right behind a
   // flag-setting instruction sees them before they are registered.
   assign bus.EXflag          = bus.IdEx_SetFlags;
   assign bus.branchFlags     = bus.forwardFlag ? flags_reg : alu_flags;
   assign bus.flags           = flags_reg;
   assign bus.ExMem_RegWrite  = reg_write_reg;
   assign bus.ExMem_MemWrite  = mem_write_reg;
   assign bus.ExMem_MemToReg  = mem_to_reg_reg;
   assign bus.ExMem_Rd        = rd_reg;
   assign bus.ExMem_ALUResult = alu_result_reg;
   assign bus.ExMem_StoreData = store_data_reg;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Directed bench for ex_stage. A behavioural model (plain arithmetic on the
//   instruction fields) predicts every output; a negedge process compares
//   the DUT against it each cycle, and hand-computed literals pin key results.
module tb_ex_stage;
   logic clk;
   logic reset_n;
   int   errors;
   int   checks;
   bit   check_en;

   ex_stage_if #(.WIDTH(64)) bus ();

   ex_stage #(.WIDTH(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   logic        m_regwrite, m_memwrite, m_memtoreg;
   logic [4:0]  m_rd;
   logic [63:0] m_alu, m_store;
   logic [3:0]  m_flags;

   function automatic logic [63:0] m_opa();
      if (bus.forwardA == 2'b10) return m_alu;
      if (bus.forwardA == 2'b01) return bus.MemWr_WriteData;
      return bus.IdEx_ReadData1;
   endfunction

   function automatic logic [63:0] m_fwdb();
      if (bus.forwardB == 2'b10) return m_alu;
      if (bus.forwardB == 2'b01) return bus.MemWr_WriteData;
      return bus.IdEx_ReadData2;
   endfunction

   function automatic logic [63:0] m_opb();
      return bus.IdEx_ALUSrc ? bus.IdEx_Imm : m_fwdb();
   endfunction

   function automatic logic [63:0] m_result();
      logic [63:0] a = m_opa();
      logic [63:0] b = m_opb();
      case (bus.IdEx_ALUOp)
         3'b000:  return b;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return a ^ b;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [3:0] m_alu_flags();
      logic [63:0] a = m_opa();
      logic [63:0] b = m_opb();
      logic [63:0] r = m_result();
      logic [64:0] wide;
      logic        c = 1'b0;
      logic        v = 1'b0;
      if (bus.IdEx_ALUOp == 3'b010) begin
         wide = {1'b0, a} + {1'b0, b};
         c = (wide > 65'h0_FFFF_FFFF_FFFF_FFFF);
         v = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(r) < 0) ||
             ($signed(a) < 0 && $signed(b) < 0 && $signed(r) >= 0);
      end else if (bus.IdEx_ALUOp == 3'b011) begin
         c = (a >= b);
         v = (($signed(a) < 0) != ($signed(b) < 0)) &&
             (($signed(r) < 0) != ($signed(a) < 0));
      end
      return {r[63], (r == 64'd0), c, v};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_regwrite <= 1'b0; m_memwrite <= 1'b0; m_memtoreg <= 1'b0;
         m_rd <= 5'd31; m_alu <= 64'd0; m_store <= 64'd0; m_flags <= 4'd0;
      end else if (bus.flush) begin
         m_regwrite <= 1'b0; m_memwrite <= 1'b0; m_memtoreg <= 1'b0;
         m_rd <= 5'd31; m_alu <= 64'd0; m_store <= 64'd0;
      end else if (!bus.stall) begin
         m_regwrite <= bus.IdEx_RegWrite;
         m_memwrite <= bus.IdEx_MemWrite;
         m_memtoreg <= bus.IdEx_MemToReg;
         m_rd       <= bus.IdEx_Rd;
         m_alu      <= m_result();
         m_store    <= m_fwdb();
         if (bus.IdEx_SetFlags) m_flags <= m_alu_flags();
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("EXflag",      64'(bus.EXflag),      64'(bus.IdEx_SetFlags));
         chk("branchFlags", 64'(bus.branchFlags),
             64'(bus.forwardFlag ? m_flags : m_alu_flags()));
         chk("flags",       64'(bus.flags),       64'(m_flags));
         chk("RegWrite",    64'(bus.ExMem_RegWrite), 64'(m_regwrite));
         chk("MemWrite",    64'(bus.ExMem_MemWrite), 64'(m_memwrite));
         chk("MemToReg",    64'(bus.ExMem_MemToReg), 64'(m_memtoreg));
         chk("Rd",          64'(bus.ExMem_Rd),    64'(m_rd));
         chk("ALUResult",   bus.ExMem_ALUResult,  m_alu);
         chk("StoreData",   bus.ExMem_StoreData,  m_store);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      bus.stall = 0; bus.flush = 0;
      bus.IdEx_RegWrite = 0; bus.IdEx_MemWrite = 0; bus.IdEx_MemToReg = 0;
      bus.IdEx_SetFlags = 0; bus.IdEx_ALUOp = 3'b000; bus.IdEx_ALUSrc = 0;
      bus.IdEx_Imm = 0; bus.IdEx_Rd = 5'd0;
      bus.IdEx_ReadData1 = 0; bus.IdEx_ReadData2 = 0;
      bus.forwardA = 2'b00; bus.forwardB = 2'b00; bus.forwardFlag = 0;
      bus.MemWr_WriteData = 0;
   endtask

   // ALU instruction: op, a (RD1), b (RD2), imm, alusrc, setflags, rd
   task automatic instr(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic src, input logic sf,
                        input logic [4:0] rd);
      set_nop();
      bus.IdEx_ALUOp = op; bus.IdEx_ReadData1 = a; bus.IdEx_ReadData2 = b;
      bus.IdEx_Imm = imm; bus.IdEx_ALUSrc = src; bus.IdEx_SetFlags = sf;
      bus.IdEx_Rd = rd; bus.IdEx_RegWrite = 1;
   endtask

   initial begin
      errors = 0; checks = 0; check_en = 0;
      reset_n = 0;
      set_nop();
      #12;
      chk("rst_RegWrite", 64'(bus.ExMem_RegWrite), 64'd0);
      chk("rst_Rd",       64'(bus.ExMem_Rd),       64'd31);
      chk("rst_flags",    64'(bus.flags),          64'd0);
      chk("rst_ALUResult", bus.ExMem_ALUResult,    64'd0);
      @(negedge clk);
      reset_n = 1;
      check_en = 1;

      // ExMem_ALUResult = 5, then ADD with forwardA=10 -> 5+3
      instr(3'b010, 64'd2, 64'd0, 64'd3, 1'b1, 1'b0, 5'd1);
      tick();
      chk("setup5", bus.ExMem_ALUResult, 64'd5);
      instr(3'b010, 64'd99, 64'd0, 64'd3, 1'b1, 1'b0, 5'd2);
      bus.forwardA = 2'b10;
      tick();
      chk("fwdA_10_add", bus.ExMem_ALUResult, 64'd8);

      // SUBS 5 - MemWr(5) with forwardB=01: live flags bypass, then registered
      instr(3'b011, 64'd5, 64'd77, 64'd0, 1'b0, 1'b1, 5'd3);
      bus.forwardB = 2'b01; bus.MemWr_WriteData = 64'd5;
      #1;
      chk("subs_branchFlags", 64'(bus.branchFlags), 64'b0110);
      tick();
      chk("subs_flags", 64'(bus.flags), 64'b0110);

      // ADDS max positive + 1 -> overflow to min negative
      instr(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1'b1, 1'b1, 5'd4);
      tick();
      chk("adds_ovf_res",   bus.ExMem_ALUResult, 64'h8000_0000_0000_0000);
      chk("adds_ovf_flags", 64'(bus.flags), 64'b1001);

      // AND without SetFlags, branch reads stored flags
      instr(3'b100, 64'hFF, 64'h0F, 64'd0, 1'b0, 1'b0, 5'd5);
      bus.forwardFlag = 1;
      #1;
      chk("and_branchFlags", 64'(bus.branchFlags), 64'b1001);
      tick();
      chk("and_flags_kept", 64'(bus.flags), 64'b1001);
      chk("and_res", bus.ExMem_ALUResult, 64'h0F);

      // stall two cycles with a new flag-setting instruction waiting
      instr(3'b011, 64'd1, 64'd9, 64'd0, 1'b0, 1'b1, 5'd6);
      bus.stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_res",   bus.ExMem_ALUResult, 64'h0F);
         chk("stall_flags", 64'(bus.flags), 64'b1001);
         chk("stall_rd",    64'(bus.ExMem_Rd), 64'd5);
      end
      // flush wins over stall
      bus.flush = 1;
      tick();
      chk("flush_rd",    64'(bus.ExMem_Rd), 64'd31);
      chk("flush_rw",    64'(bus.ExMem_RegWrite), 64'd0);
      chk("flush_res",   bus.ExMem_ALUResult, 64'd0);
      chk("flush_flags", 64'(bus.flags), 64'b1001);

      // forwardA=11 behaves as register-file select
      instr(3'b000, 64'd0, 64'd0, 64'd1, 1'b1, 1'b0, 5'd7);
      tick();
      instr(3'b010, 64'd7, 64'd0, 64'd0, 1'b1, 1'b0, 5'd8);
      bus.forwardA = 2'b11;
      tick();
      chk("fwdA_11_add", bus.ExMem_ALUResult, 64'd7);
      instr(3'b000, 64'd0, 64'd0, 64'd1, 1'b1, 1'b0, 5'd7);
      tick();
      instr(3'b000, 64'd0, 64'd7, 64'd0, 1'b0, 1'b0, 5'd9);
      bus.forwardB = 2'b11;
      tick();
      chk("fwdB_11_pass",  bus.ExMem_ALUResult, 64'd7);
      chk("fwdB_11_store", bus.ExMem_StoreData, 64'd7);

      // store forwarding from EX/MEM, with immediate operand B
      instr(3'b010, 64'h10, 64'd55, 64'd0, 1'b1, 1'b0, 5'd10);
      bus.IdEx_RegWrite = 0; bus.IdEx_MemWrite = 1; bus.forwardB = 2'b10;
      tick();
      chk("store_fwd", bus.ExMem_StoreData, 64'd7);
      chk("store_mw",  64'(bus.ExMem_MemWrite), 64'd1);

      // logic ops, unused opcodes, borrowing subtract
      instr(3'b101, 64'hF0, 64'd0, 64'h0F, 1'b1, 1'b0, 5'd11);
      tick();
      chk("orr", bus.ExMem_ALUResult, 64'hFF);
      instr(3'b110, 64'hFF, 64'd0, 64'h0F, 1'b1, 1'b0, 5'd12);
      bus.IdEx_MemToReg = 1;
      tick();
      chk("eor", bus.ExMem_ALUResult, 64'hF0);
      instr(3'b111, 64'hAB, 64'hCD, 64'd0, 1'b0, 1'b1, 5'd13);
      tick();
      chk("op111_res",   bus.ExMem_ALUResult, 64'd0);
      chk("op111_flags", 64'(bus.flags), 64'b0100);
      instr(3'b001, 64'hAB, 64'hCD, 64'd0, 1'b0, 1'b0, 5'd31);
      tick();
      chk("op001_res", bus.ExMem_ALUResult, 64'd0);
      chk("xzr_pass",  64'(bus.ExMem_Rd), 64'd31);
      instr(3'b011, 64'd3, 64'd5, 64'd0, 1'b0, 1'b1, 5'd14);
      tick();
      chk("sub_borrow_res",   bus.ExMem_ALUResult, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_borrow_flags", 64'(bus.flags), 64'b1000);

      // asynchronous reset mid-stream
      instr(3'b011, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 5'd15);
      tick();
      chk("pre_rst_rw",    64'(bus.ExMem_RegWrite), 64'd1);
      chk("pre_rst_flags", 64'(bus.flags), 64'b0110);
      #2;
      reset_n = 0;
      #1;
      chk("async_rst_rw",    64'(bus.ExMem_RegWrite), 64'd0);
      chk("async_rst_rd",    64'(bus.ExMem_Rd), 64'd31);
      chk("async_rst_flags", 64'(bus.flags), 64'd0);
      @(negedge clk);
      reset_n = 1;
      instr(3'b010, 64'd1, 64'd0, 64'd1, 1'b1, 1'b1, 5'd16);
      tick();
      chk("recover_res", bus.ExMem_ALUResult, 64'd2);
      set_nop();
      tick();
      tick();

      check_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
